// File: rtl/ppm16_modulator_if.sv
// ppm16_modulator_if: byte handshake and chip-stream bundle for the 16-PPM modulator.
//   data_in     [7:0] byte to transmit
//   data_valid        data_in valid
//   data_ready        modulator can accept data_in this cycle
//   chip_out          registered chip stream to the laser driver
//   frame_start       registered, high during the first cycle of every symbol frame
//   busy              high whenever the modulator is not idle
// Modports: master drives the byte side, slave is the modulator.
interface ppm16_modulator_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       chip_out;
    logic       frame_start;
    logic       busy;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  chip_out,
        input  frame_start,
        input  busy
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output chip_out,
        output frame_start,
        output busy
    );
endinterface

// File: rtl/ppm16_modulator.sv
// ppm16_modulator: transmit-side 16-ary PPM modulator.
// Each accepted byte becomes two symbol frames, high nibble first. A frame is 16 chip slots of
// CHIPS_PER_SLOT cycles followed by GUARD_SLOTS empty slots; the single pulse sits in the slot
// whose index equals the symbol value.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  ppm16_modulator_if.slave (data_in/data_valid/data_ready, chip_out, frame_start, busy)
// Parameters:
//   CHIPS_PER_SLOT  clock cycles per chip slot (>= 1)
//   GUARD_SLOTS     empty slots appended after every symbol frame (>= 0)
// Optional feature: define PPM16_MOD_PREAMBLE_EN to prefix every transfer taken from idle with
// two preamble frames (symbol 0x0, then 0xF). Back-to-back bytes skip the preamble.
module ppm16_modulator #(
    parameter int unsigned CHIPS_PER_SLOT = 1,
    parameter int unsigned GUARD_SLOTS    = 0
) (
    input  logic             clk,
    input  logic             rst,
    ppm16_modulator_if.slave bus
);
    localparam int unsigned NumSlots = 16 + GUARD_SLOTS;
    localparam int unsigned CycW     = (CHIPS_PER_SLOT > 1) ? $clog2(CHIPS_PER_SLOT) : 1;
    localparam int unsigned SlotW    = $clog2(NumSlots);
    localparam logic [CycW-1:0]  CycLast  = CycW'(CHIPS_PER_SLOT - 1);
    localparam logic [SlotW-1:0] SlotLast = SlotW'(NumSlots - 1);

`ifdef PPM16_MOD_PREAMBLE_EN
    typedef enum logic [2:0] {StIdle, StSymHi, StSymLo, StPre0, StPre1} state_e;
`else
    typedef enum logic [1:0] {StIdle, StSymHi, StSymLo} state_e;
`endif

    state_e           state_q, state_d;
    logic [CycW-1:0]  cyc_q, cyc_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [7:0]       byte_q, byte_d;
    logic             chip_q, chip_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;

    logic       last_cycle;
    logic       ready;
    logic       transfer;
    logic [3:0] sym_d;

    always_comb begin
        last_cycle = (cyc_q == CycLast) && (slot_q == SlotLast);
        ready      = !rst && ((state_q == StIdle) || ((state_q == StSymLo) && last_cycle));
        transfer   = bus.data_valid && ready;

        state_d = state_q;
        cyc_d   = cyc_q;
        slot_d  = slot_q;
        byte_d  = byte_q;

        if (transfer) begin
            byte_d = bus.data_in;
        end

        // Counters run only inside frames; they wrap to 0 on the last frame cycle, so every
        // new frame (and the idle state) starts from zero.
        if (state_q != StIdle) begin
            if (cyc_q == CycLast) begin
                cyc_d  = '0;
                slot_d = (slot_q == SlotLast) ? '0 : slot_q + SlotW'(1);
            end else begin
                cyc_d = cyc_q + CycW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (transfer) begin
`ifdef PPM16_MOD_PREAMBLE_EN
                    state_d = StPre0;
`else
                    state_d = StSymHi;
`endif
                end
            end
`ifdef PPM16_MOD_PREAMBLE_EN
            StPre0: if (last_cycle) state_d = StPre1;
            StPre1: if (last_cycle) state_d = StSymHi;
`endif
            StSymHi: if (last_cycle) state_d = StSymLo;
            StSymLo: if (last_cycle) state_d = transfer ? StSymHi : StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are derived from the next-state values.
        case (state_d)
            StSymHi: sym_d = byte_d[7:4];
            StSymLo: sym_d = byte_d[3:0];
`ifdef PPM16_MOD_PREAMBLE_EN
            StPre1:  sym_d = 4'hF;
`endif
            default: sym_d = 4'h0;
        endcase

        chip_d        = (state_d != StIdle) && (32'(slot_d) < 32'd16) && (slot_d[3:0] == sym_d);
        frame_start_d = (state_d != StIdle) && (cyc_d == '0) && (slot_d == '0);
        busy_d        = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cyc_q         <= '0;
            slot_q        <= '0;
            byte_q        <= '0;
            chip_q        <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            slot_q        <= slot_d;
            byte_q        <= byte_d;
            chip_q        <= chip_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.data_ready  = ready;
    assign bus.chip_out    = chip_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_ppm16_modulator.sv
// Testbench for ppm16_modulator: the driver pushes the expected frame sequence of every accepted
// byte into a queue; the monitor replays those frames cycle by cycle against the DUT outputs.
module tb_ppm16_modulator;
    localparam int S    = 2;
    localparam int G    = 1;
    localparam int FLen = (16 + G) * S;

    typedef struct {
        logic [3:0] sym;
        bit         is_lo;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ppm16_modulator_if bus ();

    ppm16_modulator #(
        .CHIPS_PER_SLOT (S),
        .GUARD_SLOTS    (G)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    frame_t exp_q[$];
    frame_t cur;
    int     mon_pos = -1;
    int     total   = 0;
    int     bad     = 0;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    // Monitor: advance the reference frame position and compare all outputs every cycle.
    always @(posedge clk) begin
        logic e_chip, e_fs, e_busy, e_ready;
        #1;
        if (rst) begin
            mon_pos = -1;
            exp_q.delete();
            check("rst_chip", bus.chip_out, 1'b0);
            check("rst_frame_start", bus.frame_start, 1'b0);
            check("rst_busy", bus.busy, 1'b0);
            check("rst_ready", bus.data_ready, 1'b0);
        end else begin
            if (mon_pos >= 0) begin
                mon_pos++;
                if (mon_pos == FLen) mon_pos = -1;
            end
            if (mon_pos == -1 && exp_q.size() > 0) begin
                cur     = exp_q.pop_front();
                mon_pos = 0;
            end
            e_busy  = (mon_pos >= 0);
            e_fs    = (mon_pos == 0);
            e_chip  = (mon_pos >= 0) && ((mon_pos / S) == int'(cur.sym));
            e_ready = (mon_pos == -1) || ((mon_pos == FLen - 1) && cur.is_lo);
            check("chip_out", bus.chip_out, e_chip);
            check("frame_start", bus.frame_start, e_fs);
            check("busy", bus.busy, e_busy);
            check("data_ready", bus.data_ready, e_ready);
        end
    end

    // All driver tasks start and end just after a falling edge.
    task automatic idle_cycles(input int n);
        repeat (n) begin
            bus.data_valid = 1'b0;
            bus.data_in    = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        bus.data_valid = 1'b1;
        bus.data_in    = b;
        #1;
        while (!bus.data_ready && waited < 1000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.data_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout at %0t: got data_ready 0 want 1", $time);
            @(negedge clk);
            bus.data_valid = 1'b0;
            return;
        end
`ifdef PPM16_MOD_PREAMBLE_EN
        if (mon_pos == -1) begin
            exp_q.push_back('{sym: 4'h0, is_lo: 1'b0});
            exp_q.push_back('{sym: 4'hF, is_lo: 1'b0});
        end
`endif
        exp_q.push_back('{sym: b[7:4], is_lo: 1'b0});
        exp_q.push_back('{sym: b[3:0], is_lo: 1'b1});
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        bus.data_valid = 1'b0;
        rst            = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic drained;
        int   waited;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        idle_cycles(100);
        send_byte(8'h51);
        idle_cycles(80);
        send_byte(8'h51);
        send_byte(8'hA3);
        idle_cycles(150);
        send_byte(8'hF0);
        idle_cycles(80);
        send_byte(8'h0F);
        idle_cycles(10);
        do_reset(2);
        idle_cycles(5);

        for (int i = 0; i < 30; i++) begin
            send_byte(8'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(0, 40)));
        end
        idle_cycles(1);

        waited = 0;
        while ((mon_pos != -1 || exp_q.size() != 0) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        drained = (mon_pos == -1) && (exp_q.size() == 0);
        check("drained", drained, 1'b1);
        idle_cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ppm16_modulator.md
Name: ppm16_modulator

Overview:
- Transmit-side 16-ary PPM modulator that feeds the optical driver on the far end of the link from the 16-PPM correlator.
- Accepts bytes over a valid/ready handshake and splits each byte into two 4-bit symbols, high nibble first (0x51 -> 5 then 1).
- Emits each symbol as a single pulse in one of 16 chip slots, followed by optional guard slots.
- Slot k carries symbol value k, so the receiver's chip index maps directly to the symbol.

Parameters:
- CHIPS_PER_SLOT, 1, clock cycles per chip slot (>=1).
- GUARD_SLOTS, 0, empty slots appended after every symbol frame (>=0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- data_in  in  8  byte to transmit
- data_valid  in  1  data_in valid
- data_ready  out  1  block can accept data_in this cycle
- chip_out  out  1  registered chip stream to laser driver
- frame_start  out  1  registered; high during first cycle of every symbol frame
- busy  out  1  high whenever not IDLE

Behaviour:
- Definitions:
  - S = CHIPS_PER_SLOT.
  - Frame = (16+GUARD_SLOTS)*S cycles: slots 0..15, then guard slots.
  - A byte occupies 2 frames.
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state IDLE, chip_out 0, frame_start 0, busy 0, all counters 0, data_ready 0 while rst is high.
- States:
  - IDLE: waiting for a byte.
  - SYM_HI: transmitting the high nibble.
  - SYM_LO: transmitting the low nibble.
  - With PPM16_MOD_PREAMBLE_EN, also PRE0 and PRE1.
- Counters:
  - cyc counter 0..S-1.
  - slot counter 0..15+GUARD_SLOTS.
  - Both reset to 0 at each frame start.
- Handshake:
  - Transfer occurs when data_valid && data_ready at a rising edge.
  - data_ready is combinational: !rst && (state==IDLE || last cycle of a SYM_LO frame).
  - The byte is captured into an 8-bit holding register on the transfer edge.
- Latency: the first frame cycle is the cycle immediately after the transfer edge, with frame_start=1 in that cycle.
- chip_out:
  - High for all S cycles of slot == current symbol; 0 in all other slots, all guard slots, and IDLE.
  - Exactly one pulse of width S per frame.
- Transitions:
  - IDLE -> SYM_HI on transfer.
  - SYM_HI -> SYM_LO after the last frame cycle.
  - SYM_LO, last frame cycle: transfer -> SYM_HI with no gap cycle; no transfer -> IDLE.
- Streaming: back-to-back bytes yield a continuous chip stream with no idle cycles between frames.
- Holding data while busy: data_valid may stay high; data_in is ignored except on transfer edges.
- Reset mid-operation: the next edge forces IDLE and chip_out 0; the in-flight byte is discarded and never resumed.
- busy equals (state != IDLE), registered with the state.

Optional Feature:
- Macro: PPM16_MOD_PREAMBLE_EN.
- Enabled:
  - A transfer accepted from IDLE first sends two preamble frames, symbol 0x0 then symbol 0xF, then SYM_HI and SYM_LO.
  - frame_start pulses for every frame, including preamble frames.
  - Back-to-back transfers taken at the end of SYM_LO skip the preamble.
  - States: IDLE -> PRE0 -> PRE1 -> SYM_HI.
- Disabled: PRE0 and PRE1 do not exist; timing is exactly as above.

Test Plan:
- S=1, G=0: send 0x51 once (transfer at cycle T) -> chip_out=1 only at cycles T+1+5 and T+1+17; frame_start at T+1 and T+17; busy for 32 cycles; then IDLE with data_ready=1.
- S=1, G=0: send 0x51 then 0xA3 back-to-back -> 64 contiguous cycles; pulses at offsets 5, 17, 42, 51; second transfer occurs on offset 31.
- S=2, G=1: send 0xF0 -> frame 34 cycles; chip_out high at offsets 30-31 and 34-35; no pulse in guard offsets 32-33 or 66-67.
- rst asserted at offset 10 of SYM_HI while sending 0x0F -> next cycle chip_out=0, busy=0; no pulse at offset 31; data_ready=1 after rst drops.
- data_valid low for 100 cycles after reset -> chip_out, frame_start, busy all 0; data_ready=1 throughout.
- PPM16_MOD_PREAMBLE_EN, S=1, G=0: send 0x51 -> pulses at offsets 0, 31, 37, 49; a back-to-back second byte gets no preamble.
